burst_toggle_gen: RTL and testbench

//  Parametrised, multi-channel, synthesizable toggle/clock generator. Each channel

---
 rtl/burst_toggle_gen_if.sv | 32 +++
 rtl/burst_toggle_gen.sv | 140 ++++++++++++++
 tb/tb_burst_toggle_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/burst_toggle_gen_if.sv
// Bundle of control and status signals for burst_toggle_gen.
// The master side issues per-channel requests and configuration.
// The slave side (the generator) returns the toggle outputs and status.
interface burst_toggle_gen_if #(
  parameter int CH    = 4,
  parameter int HP_W  = 8,
  parameter int REP_W = 8
);

  // Per-channel requests and configuration, packed channel by channel
  logic [CH-1:0]       start;
  logic [CH-1:0]       abort;
  logic [CH-1:0]       mode;
  logic [CH*HP_W-1:0]  half_p;
  logic [CH*REP_W-1:0] reps;

  // Per-channel generated outputs and status
  logic [CH-1:0]       tgl_out;
  logic [CH-1:0]       busy;
  logic [CH-1:0]       done;

  modport master (
    output start, abort, mode, half_p, reps,
    input  tgl_out, busy, done
  );

  modport slave (
    input  start, abort, mode, half_p, reps,
    output tgl_out, busy, done
  );

endinterface

// File: rtl/burst_toggle_gen.sv
// Multi-channel toggle / pulse-train generator.
// Each channel inverts its output every H cycles of clk, either for a fixed
// number of toggles (burst, mode=0) or until aborted (continuous, mode=1).
// Configuration is captured on the accepted start edge and held for the run.
// All outputs come straight from flops: no input reaches an output
// combinationally.
module burst_toggle_gen #(
  parameter int            CH       = 4,
  parameter int            HP_W     = 8,
  parameter int            REP_W    = 8,
  parameter logic [CH-1:0] INIT_LVL = '0
) (
  input  logic              clk,
  input  logic              rst,
  burst_toggle_gen_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-channel state, current (_q) and next (_d)
  state_t                     state_q [CH];
  state_t                     state_d [CH];
  logic [CH-1:0]              mode_q,  mode_d;
  logic [CH-1:0][HP_W-1:0]    hp_q,    hp_d;
  logic [CH-1:0][HP_W-1:0]    cnt_q,   cnt_d;
  logic [CH-1:0][REP_W-1:0]   rem_q,   rem_d;
  logic [CH-1:0]              tgl_q,   tgl_d;
  logic [CH-1:0]              busy_q,  busy_d;
  logic [CH-1:0]              done_q,  done_d;

  // Unpacked views of the flat configuration buses
  logic [CH-1:0][HP_W-1:0]    hp_in;
  logic [CH-1:0][REP_W-1:0]   reps_in;

  for (genvar g = 0; g < CH; g++) begin : g_slice
    assign hp_in[g]   = bus.half_p[g*HP_W +: HP_W];
    assign reps_in[g] = bus.reps[g*REP_W +: REP_W];
  end

  // Next-state and next-output logic for every channel
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // NOTE: every variable gets its hold value first, so no path through
      // the case below can leave one unassigned and infer a latch.
      state_d[i] = state_q[i];
      mode_d[i]  = mode_q[i];
      hp_d[i]    = hp_q[i];
      cnt_d[i]   = cnt_q[i];
      rem_d[i]   = rem_q[i];
      tgl_d[i]   = tgl_q[i];
      busy_d[i]  = busy_q[i];
      done_d[i]  = 1'b0;

      case (state_q[i])
        IDLE: begin
          // abort beats start; abort on its own does nothing in IDLE
          if (bus.start[i] && !bus.abort[i]) begin
            if (!bus.mode[i] && (reps_in[i] == '0)) begin
              // Zero-length burst: no run, just report completion
              done_d[i] = 1'b1;
            end else begin
              state_d[i] = RUN;
              busy_d[i]  = 1'b1;
              cnt_d[i]   = '0;
              mode_d[i]  = bus.mode[i];
              hp_d[i]    = (hp_in[i] == '0) ? HP_W'(1) : hp_in[i];
              rem_d[i]   = reps_in[i];
            end
          end
        end

        RUN: begin
          if (bus.abort[i]) begin
            // Abort also wins over a toggle due on this same edge
            state_d[i] = IDLE;
            busy_d[i]  = 1'b0;
            tgl_d[i]   = INIT_LVL[i];
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == hp_q[i] - HP_W'(1)) begin
            tgl_d[i] = ~tgl_q[i];
            cnt_d[i] = '0;
            if (!mode_q[i]) begin
              rem_d[i] = rem_q[i] - REP_W'(1);
              if (rem_q[i] == REP_W'(1)) begin
                // Final toggle of the burst: output keeps its new level
                state_d[i] = IDLE;
                busy_d[i]  = 1'b0;
                done_d[i]  = 1'b1;
              end
            end
          end else begin
            cnt_d[i] = cnt_q[i] + HP_W'(1);
          end
        end

        default: begin
          state_d[i] = IDLE;
          busy_d[i]  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, asynchronously reset to the idle values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
      end
      mode_q <= '0;
      hp_q   <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      tgl_q  <= INIT_LVL;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
      end
      mode_q <= mode_d;
      hp_q   <= hp_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      tgl_q  <= tgl_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.tgl_out = tgl_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_burst_toggle_gen.sv
// Directed bench for burst_toggle_gen: a vector table for the single-channel
// scenarios plus hand-written sequences for multi-channel runs, a final
// toggle colliding with abort, and asynchronous reset in mid-burst.
// Expected toggle levels are written relative to INIT (1 = inverted).
module tb_burst_toggle_gen;

  localparam int            CH    = 4;
  localparam int            HP_W  = 8;
  localparam int            REP_W = 8;
  localparam logic [CH-1:0] INIT  = 4'b1010;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  burst_toggle_gen_if #(.CH(CH), .HP_W(HP_W), .REP_W(REP_W)) bus ();

  burst_toggle_gen #(
    .CH(CH), .HP_W(HP_W), .REP_W(REP_W), .INIT_LVL(INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] start;
    logic [3:0] abort;
    logic [3:0] mode;
    logic [31:0] hp;
    logic [31:0] rp;
    logic [3:0] e_inv;
    logic [3:0] e_busy;
    logic [3:0] e_done;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(string nm, logic [3:0] st, logic [3:0] ab,
                              logic [3:0] md, logic [31:0] hp, logic [31:0] rp,
                              logic [3:0] ei, logic [3:0] eb, logic [3:0] ed);
    vec_t v;
    v.name = nm; v.start = st; v.abort = ab; v.mode = md; v.hp = hp; v.rp = rp;
    v.e_inv = ei; v.e_busy = eb; v.e_done = ed;
    tbl.push_back(v);
  endfunction

  task automatic drive(logic [3:0] st, logic [3:0] ab, logic [3:0] md,
                       logic [31:0] hp, logic [31:0] rp);
    bus.start  = st;
    bus.abort  = ab;
    bus.mode   = md;
    bus.half_p = hp;
    bus.reps   = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [3:0] e_inv, logic [3:0] e_busy,
                       logic [3:0] e_done);
    logic [3:0] e_tgl;
    e_tgl = INIT ^ e_inv;
    n_vec++;
    if (bus.tgl_out !== e_tgl || bus.busy !== e_busy || bus.done !== e_done) begin
      n_bad++;
      $display("FAIL %s: tgl/busy/done got %b/%b/%b expected %b/%b/%b",
               name, bus.tgl_out, bus.busy, bus.done, e_tgl, e_busy, e_done);
    end
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    int h [4];
    logic [3:0] inv;

    drive('0, '0, '0, '0, '0);
    rst = 1'b1;
    #2;
    check("reset_asserted", 4'b0000, 4'b0000, 4'b0000);
    #10 rst = 1'b0;

    // Idle hold: nothing may move without a start
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_hold", 4'b0000, 4'b0000, 4'b0000);
    end

    // ch0 burst H=3, reps=4; config changed mid-run has no effect
    add("c0_start", 4'b0001, 4'b0000, 4'b0000, 32'h0000_0003, 32'h0000_0004, 4'b0000, 4'b0001, 4'b0000);
    add("c0_k1",    4'b0000, 4'b0000, 4'b0001, 32'h0000_00FF, 32'h0000_0001, 4'b0000, 4'b0001, 4'b0000);
    add("c0_k2",    4'b0000, 4'b0000, 4'b0000, 32'h0000_00FF, 32'h0000_0001, 4'b0000, 4'b0001, 4'b0000);
    add("c0_k3",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0001, 32'h0000_0009, 4'b0001, 4'b0001, 4'b0000);
    add("c0_k4",    4'b0001, 4'b0000, 4'b0000, 32'h0000_0001, 32'h0000_0001, 4'b0001, 4'b0001, 4'b0000);
    add("c0_k5",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0001, 4'b0001, 4'b0000);
    add("c0_k6",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0001, 4'b0000);
    add("c0_k7",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0001, 4'b0000);
    add("c0_k8",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0001, 4'b0000);
    add("c0_k9",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0001, 4'b0001, 4'b0000);
    add("c0_k10",   4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0001, 4'b0001, 4'b0000);
    add("c0_k11",   4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0001, 4'b0001, 4'b0000);
    add("c0_last",  4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0001);
    add("c0_after", 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000);
    // ch2 zero-length burst, then start+abort together
    add("c2_rep0",  4'b0100, 4'b0000, 4'b0000, 32'h0003_0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0100);
    add("c2_rep0b", 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000);
    add("c2_stab",  4'b0100, 4'b0100, 4'b0000, 32'h0001_0000, 32'h0005_0000, 4'b0000, 4'b0000, 4'b0000);
    add("c2_stabb", 4'b0000, 4'b0000, 4'b0000, 32'h0001_0000, 32'h0005_0000, 4'b0000, 4'b0000, 4'b0000);
    // ch1 continuous with half_p=0 (treated as 1), then abort
    add("c1_start", 4'b0010, 4'b0000, 4'b0010, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0010, 4'b0000);
    add("c1_k1",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0500, 32'h0000_0000, 4'b0010, 4'b0010, 4'b0000);
    add("c1_k2",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0010, 4'b0000);
    add("c1_k3",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0010, 4'b0010, 4'b0000);
    add("c1_abort", 4'b0000, 4'b0010, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000);
    add("c1_idle",  4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000);
    // ch3 odd burst (H=1, reps=3) keeps inverted level; abort in IDLE is inert
    add("c3_start", 4'b1000, 4'b0000, 4'b0000, 32'h0100_0000, 32'h0300_0000, 4'b0000, 4'b1000, 4'b0000);
    add("c3_k1",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b1000, 4'b1000, 4'b0000);
    add("c3_k2",    4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b1000, 4'b0000);
    add("c3_last",  4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b1000, 4'b0000, 4'b1000);
    add("c3_hold",  4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b1000, 4'b0000, 4'b0000);
    add("c3_idlab", 4'b0000, 4'b1000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b1000, 4'b0000, 4'b0000);

    foreach (tbl[j]) begin
      drive(tbl[j].start, tbl[j].abort, tbl[j].mode, tbl[j].hp, tbl[j].rp);
      tick();
      check(tbl[j].name, tbl[j].e_inv, tbl[j].e_busy, tbl[j].e_done);
    end
    drive('0, '0, '0, '0, '0);

    // All four channels continuous with H = 1,2,3,5; restart attempts and
    // config changes mid-run must not disturb the periods
    pulse_reset();
    h = '{1, 2, 3, 5};
    drive(4'b1111, 4'b0000, 4'b1111, {8'd5, 8'd3, 8'd2, 8'd1}, '0);
    tick();
    check("all_start", 4'b0000, 4'b1111, 4'b0000);
    for (int k = 1; k <= 30; k++) begin
      if (k == 4)
        drive(4'b1111, 4'b0000, 4'b0000, {8'd7, 8'd7, 8'd7, 8'd7}, {4{8'd1}});
      else
        drive(4'b0000, 4'b0000, 4'b0000, {8'd9, 8'd9, 8'd9, 8'd9}, '0);
      tick();
      for (int c = 0; c < 4; c++) inv[c] = ((k / h[c]) % 2) == 1;
      check("all_run", inv, 4'b1111, 4'b0000);
    end
    drive('0, 4'b1111, '0, '0, '0);
    tick();
    check("all_abort", 4'b0000, 4'b0000, 4'b0000);

    // ch0 burst H=2, reps=3: abort on the edge of the final toggle
    drive(4'b0001, 4'b0000, 4'b0000, 32'h0000_0002, 32'h0000_0003);
    tick();
    check("fin_start", 4'b0000, 4'b0001, 4'b0000);
    drive('0, '0, '0, '0, '0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      inv = {3'b000, ((k / 2) % 2) == 1};
      check("fin_run", inv, 4'b0001, 4'b0000);
    end
    drive('0, 4'b0001, '0, '0, '0);
    tick();
    check("fin_abort", 4'b0000, 4'b0000, 4'b0000);
    drive('0, '0, '0, '0, '0);
    tick();
    check("fin_nodone", 4'b0000, 4'b0000, 4'b0000);

    // Asynchronous reset in the middle of a burst, away from any clock edge
    drive(4'b0001, 4'b0000, 4'b0000, 32'h0000_0002, 32'h0000_000A);
    tick();
    drive('0, '0, '0, '0, '0);
    tick(); tick(); tick();
    check("rst_pre", 4'b0001, 4'b0001, 4'b0000);
    #3 rst = 1'b1;
    #1;
    check("rst_async", 4'b0000, 4'b0000, 4'b0000);
    tick();
    check("rst_held", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    tick();
    check("rst_idle", 4'b0000, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
